// File: rtl/serial_therm2scomp_conv.sv
// Bit-serial thermometer-to-two's-complement converter: counts ones in a THERM_LEN-bit
// word, applies an optional offset, saturates to OUT_W and presents it on valid/ready.
module serial_therm2scomp_conv #(
  parameter int unsigned THERM_LEN = 31,
  parameter int unsigned OUT_W     = 5,
  parameter int unsigned OFFSET    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_bubble,
  output logic             out_sat
);

  localparam int unsigned CNT_W = $clog2(THERM_LEN + 1);
  localparam int unsigned S_W   = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;
  localparam logic signed [S_W-1:0] SMAX = S_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [S_W-1:0] SMIN = ~SMAX;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(THERM_LEN - 1);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        bit_idx;
  logic [CNT_W-1:0]        count;
  logic                    seen0;
  logic                    bubble;
  logic                    mode_q;

  logic                    accept;
  logic                    mode_eff;
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    bubble_nxt;
  logic signed [S_W-1:0]   r_val;
  logic [OUT_W-1:0]        res;
  logic                    res_sat;

  // Word result as it would be if the bit presented now is the last one.
  always_comb begin
    accept     = (state == COLLECT) && in_valid;
    mode_eff   = (bit_idx == '0) ? mode : mode_q;
    cnt_nxt    = count + CNT_W'(in_bit);
    bubble_nxt = bubble | (in_bit & seen0);
    r_val      = mode_eff ? S_W'(cnt_nxt) : (S_W'(cnt_nxt) - S_W'(OFFSET));
    res        = r_val[OUT_W-1:0];
    res_sat    = 1'b0;
    if (r_val > SMAX) begin
      res     = SMAX[OUT_W-1:0];
      res_sat = 1'b1;
    end else if (r_val < SMIN) begin
      res     = SMIN[OUT_W-1:0];
      res_sat = 1'b1;
    end
  end

  // Collect/hold sequencer; in_ready is kept as a flop mirroring state == COLLECT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      bit_idx    <= '0;
      count      <= '0;
      seen0      <= 1'b0;
      bubble     <= 1'b0;
      mode_q     <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_bubble <= 1'b0;
      out_sat    <= 1'b0;
    end else if (clear) begin
      state     <= COLLECT;
      bit_idx   <= '0;
      count     <= '0;
      seen0     <= 1'b0;
      bubble    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (bit_idx == '0) mode_q <= mode;
            if (bit_idx == LAST_IDX) begin
              out_data   <= res;
              out_bubble <= bubble_nxt;
              out_sat    <= res_sat;
              out_valid  <= 1'b1;
              in_ready   <= 1'b0;
              state      <= HOLD;
            end
            bit_idx <= bit_idx + CNT_W'(1);
            count   <= cnt_nxt;
            bubble  <= bubble_nxt;
            if (!in_bit) seen0 <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            bit_idx   <= '0;
            count     <= '0;
            seen0     <= 1'b0;
            bubble    <= 1'b0;
            in_ready  <= 1'b1;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_therm2scomp_conv.sv
// Randomized self-checking bench for serial_therm2scomp_conv against an arithmetic model.
module tb_serial_therm2scomp_conv;

  logic       clk = 1'b0;
  logic       rst_n, clear, mode, in_valid, in_ready, in_bit;
  logic       out_valid, out_ready, out_bubble, out_sat;
  logic [4:0] out_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  serial_therm2scomp_conv #(.THERM_LEN(31), .OUT_W(5), .OFFSET(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bubble(out_bubble), .out_sat(out_sat)
  );

  // Reference: count ones, detect any 1 after a 0, offset or not, clip to [-16,15].
  function automatic void model(input logic [30:0] w, input logic m,
                                output logic [4:0] d, output logic b, output logic s);
    int k = 0;
    int r;
    bit z = 0;
    b = 1'b0;
    for (int i = 0; i < 31; i++) begin
      if (w[i]) begin k++; if (z) b = 1'b1; end
      else z = 1;
    end
    r = m ? k : k - 16;
    s = 1'b0;
    if (r > 15) begin r = 15; s = 1'b1; end
    else if (r < -16) begin r = -16; s = 1'b1; end
    d = 5'(r);
  endfunction

  // Feeds nbits of w LSB first; mode is presented as m only until the first bit is taken.
  task automatic send_bits(input logic [30:0] w, input logic m, input int gap_pct,
                           input int nbits, output bit tmo, output logic pre_ov);
    int i = 0;
    int guard = 0;
    logic v;
    tmo = 0;
    pre_ov = 1'b0;
    while (i < nbits) begin
      @(negedge clk);
      guard++;
      if (guard > 1000) begin tmo = 1; break; end
      v = ($urandom_range(99) >= 32'(gap_pct)) ? 1'b1 : 1'b0;
      in_valid = v;
      in_bit   = w[i];
      mode     = (i == 0) ? m : ~m;
      pre_ov   = out_valid;
      if (v && in_ready) i++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_word(input string nm, input logic [30:0] w, input logic m, input int gap);
    logic [4:0] ed;
    logic eb, es, pov;
    bit tmo;
    model(w, m, ed, eb, es);
    send_bits(w, m, gap, 31, tmo, pov);
    total_cnt++; if (tmo !== 1'b0) $display("FAIL %s_timeout got=%0d exp=0", nm, tmo); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL %s_valid got=%b exp=1", nm, out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== ed) $display("FAIL %s_data w=%h m=%b got=%h exp=%h", nm, w, m, out_data, ed); else pass_cnt++;
    total_cnt++; if (out_bubble !== eb) $display("FAIL %s_bubble w=%h got=%b exp=%b", nm, w, out_bubble, eb); else pass_cnt++;
    total_cnt++; if (out_sat !== es) $display("FAIL %s_sat w=%h m=%b got=%b exp=%b", nm, w, m, out_sat, es); else pass_cnt++;
    handshake();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL %s_release got=%b exp=0", nm, out_valid); else pass_cnt++;
  endtask

  function automatic logic [30:0] ones(input int k);
    logic [31:0] t = (32'd1 << k) - 32'd1;
    return t[30:0];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; mode = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 5'h00) $display("FAIL reset_data got=%h exp=00", out_data); else pass_cnt++;
    total_cnt++; if ({out_bubble, out_sat} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {out_bubble, out_sat}); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", in_ready); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sweep();
    for (int k = 0; k <= 31; k++) run_word("sweep", ones(k), 1'b0, 0);
  endtask

  task automatic test_mode1();
    run_word("mode1_sat", ones(20), 1'b1, 0);
    run_word("mode1_7", ones(7), 1'b1, 0);
    total_cnt++; if (5'h07 !== 5'(7)) $display("FAIL mode1_const"); else pass_cnt++;
  endtask

  task automatic test_bubble();
    run_word("bubble", 31'h17, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    logic [30:0] w;
    logic [4:0] ed;
    logic eb, es, pov;
    bit tmo;
    w = 31'($urandom);
    model(w, 1'b0, ed, eb, es);
    send_bits(w, 1'b0, 0, 31, tmo, pov);
    total_cnt++; if (tmo !== 1'b0) $display("FAIL bp_timeout got=%0d exp=0", tmo); else pass_cnt++;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_bit = 1'b1;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_valid c=%0d got=%b exp=1", c, out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== ed) $display("FAIL bp_data c=%0d got=%h exp=%h", c, out_data, ed); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready c=%0d got=%b exp=0", c, in_ready); else pass_cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    handshake();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after got=%b exp=1", in_ready); else pass_cnt++;
    run_word("bp_next", ones(24), 1'b0, 0);
  endtask

  task automatic test_gapped();
    logic pov;
    bit tmo;
    send_bits(ones(16), 1'b0, 45, 31, tmo, pov);
    total_cnt++; if (tmo !== 1'b0) $display("FAIL gap_timeout got=%0d exp=0", tmo); else pass_cnt++;
    total_cnt++; if (pov !== 1'b0) $display("FAIL gap_early_valid got=%b exp=0", pov); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL gap_latency got=%b exp=1", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 5'h00) $display("FAIL gap_data got=%h exp=00", out_data); else pass_cnt++;
    handshake();
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      logic [30:0] w;
      if ($urandom_range(1) == 0) w = 31'($urandom);
      else w = ones(int'($urandom_range(31)));
      run_word("rand", w, 1'($urandom_range(1)), int'($urandom_range(50)));
    end
  endtask

  task automatic test_clear_reset();
    logic pov;
    bit tmo;
    // clear mid-word, with a bit presented alongside it
    send_bits(31'h3FF, 1'b0, 0, 10, tmo, pov);
    clear = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL clr_novalid got=%b exp=0", out_valid); else pass_cnt++;
    run_word("clr_next", ones(25), 1'b0, 0);
    // reset mid-word
    send_bits(31'h155, 1'b0, 0, 10, tmo, pov);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_novalid got=%b exp=0", out_valid); else pass_cnt++;
    run_word("rst_next", ones(25), 1'b0, 0);
    // clear while holding a result
    send_bits(ones(3), 1'b0, 0, 31, tmo, pov);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL clr_hold got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL clr_hold_ready got=%b exp=1", in_ready); else pass_cnt++;
    run_word("clr_hold_next", ones(25), 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_mode1();
    test_bubble();
    test_backpressure();
    test_gapped();
    test_random();
    test_clear_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
